// File: rtl/debug_display_pkg.sv
// Shared constants and helpers for the debug display pager: blank glyph,
// hex-to-seven-segment table and page-count arithmetic.
package debug_display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segments are active-low, ordered {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_glyph(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  function automatic int num_pages(input int data_w, input int num_digits);
    return (data_w + 4 * num_digits - 1) / (4 * num_digits);
  endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// One seven-segment digit: hex glyph lookup with a blanking override.
module hex_seg_decoder
  import debug_display_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : hex_glyph(nibble);
  end

endmodule

// File: rtl/debug_display_pager.sv
// Button-paged seven-segment viewer for one of N_CH monitored words, with freeze.
// Optional periodic page advance is built when DEBUG_DISPLAY_PAGER_AUTOSCROLL_EN is defined.
module debug_display_pager
  import debug_display_pkg::*;
#(
  parameter int N_CH         = 6,
  parameter int DATA_W       = 32,
  parameter int NUM_DIGITS   = 6,
  parameter int SEL_W        = 3,
  parameter int SCROLL_TICKS = 50000000,
  localparam int NUM_PAGES   = num_pages(DATA_W, NUM_DIGITS),
  localparam int PAGE_W      = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic                     step_in,
  input  logic                     freeze_in,
  output logic [7*NUM_DIGITS-1:0]  hex_out,
  output logic [2+PAGE_W-1:0]      led_out
);

  localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(NUM_PAGES - 1);

  if (SCROLL_TICKS < 1) begin : g_bad_scroll_ticks
    $error("SCROLL_TICKS must be at least 1");
  end

  logic [SEL_W-1:0]        sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d, sel_s3_q, sel_s3_d;
  logic                    step_s1_q, step_s1_d, step_s2_q, step_s2_d, step_s3_q, step_s3_d;
  logic                    frz_s1_q, frz_s1_d, frz_s2_q, frz_s2_d, frz_s3_q, frz_s3_d;
  logic [PAGE_W-1:0]       page_q, page_d;
  logic                    frozen_q, frozen_d;
  logic [DATA_W-1:0]       snapshot_q, snapshot_d;
  logic                    valid_q, valid_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [2+PAGE_W-1:0]     led_q, led_d;

  logic              step_evt;
  logic              freeze_evt;
  logic              sel_change;
  logic              sel_err;
  logic              scroll_tc;
  logic              advance;
  logic [DATA_W-1:0] sel_word;
  logic [6:0]        digit_seg [NUM_DIGITS];

  assign step_evt   = step_s2_q & ~step_s3_q;
  assign freeze_evt = frz_s2_q & ~frz_s3_q;
  assign sel_change = (sel_s2_q != sel_s3_q);
  assign sel_err    = (int'(sel_s2_q) >= N_CH);
  assign advance    = step_evt | scroll_tc;

`ifdef DEBUG_DISPLAY_PAGER_AUTOSCROLL_EN
  localparam int SCROLL_W = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
  localparam logic [SCROLL_W-1:0] SCROLL_LAST = SCROLL_W'(SCROLL_TICKS - 1);

  logic [SCROLL_W-1:0] scroll_cnt_q, scroll_cnt_d;

  assign scroll_tc = (scroll_cnt_q == SCROLL_LAST);

  // A manual step or a new channel restarts the full scroll period.
  always_comb begin
    scroll_cnt_d = scroll_cnt_q + 1'b1;
    if (sel_change || step_evt || scroll_tc) begin
      scroll_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scroll_cnt_q <= '0;
    end else begin
      scroll_cnt_q <= scroll_cnt_d;
    end
  end
`else
  assign scroll_tc = 1'b0;
`endif

  // Out-of-range selects read as zero rather than aliasing another channel.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (sel_s2_q == SEL_W'(k)) begin
        sel_word = ch_data[k*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    logic [3:0] nibble;
    logic       blank;
    int         bit_pos;

    always_comb begin
      bit_pos = 4 * (int'(page_q) * NUM_DIGITS + d);
      blank   = (bit_pos >= DATA_W);
      nibble  = 4'(snapshot_q >> bit_pos);
    end

    hex_seg_decoder u_dec (
      .nibble (nibble),
      .blank  (blank),
      .seg    (digit_seg[d])
    );
  end

  always_comb begin
    sel_s1_d  = sel_in;
    sel_s2_d  = sel_s1_q;
    sel_s3_d  = sel_s2_q;
    step_s1_d = step_in;
    step_s2_d = step_s1_q;
    step_s3_d = step_s2_q;
    frz_s1_d  = freeze_in;
    frz_s2_d  = frz_s1_q;
    frz_s3_d  = frz_s2_q;

    // A channel change wins over any same-cycle advance.
    page_d = page_q;
    if (sel_change) begin
      page_d = '0;
    end else if (advance) begin
      page_d = (page_q == PAGE_LAST) ? '0 : page_q + 1'b1;
    end

    frozen_d   = frozen_q ^ freeze_evt;
    snapshot_d = frozen_q ? snapshot_q : (sel_err ? '0 : sel_word);
    valid_d    = 1'b1;

    // valid_q keeps the first cycle after reset blank, before the snapshot is loaded.
    hex_d = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      hex_d[7*d +: 7] = valid_q ? digit_seg[d] : SEG_BLANK;
    end
    led_d = {page_q, sel_err, frozen_q};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sel_s1_q   <= '0;
      sel_s2_q   <= '0;
      sel_s3_q   <= '0;
      step_s1_q  <= 1'b0;
      step_s2_q  <= 1'b0;
      step_s3_q  <= 1'b0;
      frz_s1_q   <= 1'b0;
      frz_s2_q   <= 1'b0;
      frz_s3_q   <= 1'b0;
      page_q     <= '0;
      frozen_q   <= 1'b0;
      snapshot_q <= '0;
      valid_q    <= 1'b0;
      hex_q      <= {NUM_DIGITS{SEG_BLANK}};
      led_q      <= '0;
    end else begin
      sel_s1_q   <= sel_s1_d;
      sel_s2_q   <= sel_s2_d;
      sel_s3_q   <= sel_s3_d;
      step_s1_q  <= step_s1_d;
      step_s2_q  <= step_s2_d;
      step_s3_q  <= step_s3_d;
      frz_s1_q   <= frz_s1_d;
      frz_s2_q   <= frz_s2_d;
      frz_s3_q   <= frz_s3_d;
      page_q     <= page_d;
      frozen_q   <= frozen_d;
      snapshot_q <= snapshot_d;
      valid_q    <= valid_d;
      hex_q      <= hex_d;
      led_q      <= led_d;
    end
  end

  assign hex_out = hex_q;
  assign led_out = led_q;

endmodule

// File: tb/tb_debug_display_pager.sv
// Bench for debug_display_pager: cycle reference model feeding an expected queue,
// negedge monitor comparing, plus directed display checks.
module tb_debug_display_pager;

  localparam int N_CH         = 6;
  localparam int DATA_W       = 32;
  localparam int NUM_DIGITS   = 6;
  localparam int SEL_W        = 3;
  localparam int SCROLL_TICKS = 8;
  localparam int NP           = 2;
  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ch_w [N_CH];
  logic [N_CH*DATA_W-1:0] ch_data;
  logic [SEL_W-1:0] sel_in = '0;
  logic        step_in = 1'b0;
  logic        freeze_in = 1'b0;
  logic [41:0] hex_out;
  logic [2:0]  led_out;

  int n_assert = 0;
  int n_fail   = 0;
  logic [44:0] exp_q [$];

  // reference model state
  int          m_page;
  int          m_cnt;
  logic        m_frozen;
  logic        m_valid;
  logic [31:0] m_snap;
  logic [SEL_W-1:0] h_sel [3];
  logic        h_step [3];
  logic        h_frz [3];

  debug_display_pager #(
    .N_CH(N_CH), .DATA_W(DATA_W), .NUM_DIGITS(NUM_DIGITS),
    .SEL_W(SEL_W), .SCROLL_TICKS(SCROLL_TICKS)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ch_data   (ch_data),
    .sel_in    (sel_in),
    .step_in   (step_in),
    .freeze_in (freeze_in),
    .hex_out   (hex_out),
    .led_out   (led_out)
  );

  // clock / reset
  always #5 clock = ~clock;

  always_comb begin
    ch_data = '0;
    for (int k = 0; k < N_CH; k++) ch_data[k*DATA_W +: DATA_W] = ch_w[k];
  end

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40; 4'h1: g = 7'h79; 4'h2: g = 7'h24; 4'h3: g = 7'h30;
      4'h4: g = 7'h19; 4'h5: g = 7'h12; 4'h6: g = 7'h02; 4'h7: g = 7'h78;
      4'h8: g = 7'h00; 4'h9: g = 7'h10; 4'hA: g = 7'h08; 4'hB: g = 7'h03;
      4'hC: g = 7'h46; 4'hD: g = 7'h21; 4'hE: g = 7'h06; default: g = 7'h0E;
    endcase
    return g;
  endfunction

  function automatic logic [41:0] render(input logic [31:0] snap, input int page);
    logic [41:0] r;
    int pos;
    r = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      pos = 4 * (page * NUM_DIGITS + d);
      r[7*d +: 7] = (pos >= DATA_W) ? 7'h7F : glyph(4'(snap >> pos));
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model one clock edge: synchronised inputs are the samples from two and three edges ago.
  task automatic model_step();
    logic [SEL_W-1:0] sel_now;
    logic sel_chg, err, step_evt, frz_evt, adv, term;
    if (reset) begin
      m_page = 0; m_cnt = 0; m_frozen = 1'b0; m_valid = 1'b0; m_snap = '0;
      for (int i = 0; i < 3; i++) begin
        h_sel[i] = '0; h_step[i] = 1'b0; h_frz[i] = 1'b0;
      end
      exp_q.push_back({3'b000, ALL_BLANK});
    end else begin
      sel_now  = h_sel[1];
      sel_chg  = (h_sel[1] != h_sel[2]);
      err      = (int'(sel_now) >= N_CH);
      step_evt = h_step[1] && !h_step[2];
      frz_evt  = h_frz[1] && !h_frz[2];
      exp_q.push_back({1'(m_page), err, m_frozen,
                       m_valid ? render(m_snap, m_page) : ALL_BLANK});
      adv = step_evt;
`ifdef DEBUG_DISPLAY_PAGER_AUTOSCROLL_EN
      term  = (m_cnt == SCROLL_TICKS - 1);
      adv   = adv || term;
      m_cnt = (sel_chg || step_evt || term) ? 0 : m_cnt + 1;
`else
      term  = 1'b0;
`endif
      if (!m_frozen) m_snap = err ? 32'h0 : ch_w[sel_now];
      if (sel_chg) m_page = 0;
      else if (adv) m_page = (m_page + 1) % NP;
      if (frz_evt) m_frozen = !m_frozen;
      m_valid = 1'b1;
      h_sel[2] = h_sel[1]; h_sel[1] = h_sel[0]; h_sel[0] = sel_in;
      h_step[2] = h_step[1]; h_step[1] = h_step[0]; h_step[0] = step_in;
      h_frz[2] = h_frz[1]; h_frz[1] = h_frz[0]; h_frz[0] = freeze_in;
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // scoreboard monitor
  initial forever begin
    logic [44:0] e;
    @(negedge clock);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("hex_out", 64'(hex_out), 64'(e[41:0]));
      check("led_out", 64'(led_out), 64'(e[44:42]));
    end
  end

  // driver tasks
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse_step();
    step_in = 1'b1; wait_cycles(1); step_in = 1'b0;
  endtask

  task automatic pulse_freeze();
    freeze_in = 1'b1; wait_cycles(1); freeze_in = 1'b0;
  endtask

  task automatic randomize_inputs();
    sel_in    = 3'($urandom_range(0, 7));
    step_in   = 1'($urandom_range(0, 1));
    freeze_in = 1'($urandom_range(0, 1));
    for (int k = 0; k < N_CH; k++) ch_w[k] = $urandom;
  endtask

  initial begin
    for (int k = 0; k < N_CH; k++) ch_w[k] = '0;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_cycles(1);
      randomize_inputs();
    end
    @(negedge clock);
    check("reset_hex", 64'(hex_out), 64'(ALL_BLANK));
    check("reset_led", 64'(led_out), 64'h0);
    wait_cycles(1);

    reset = 1'b0; sel_in = 3'd1; step_in = 1'b0; freeze_in = 1'b0;
    ch_w[1] = 32'h12345678;
    @(posedge clock);
    @(negedge clock);
    check("post_reset_hex", 64'(hex_out), 64'(ALL_BLANK));
    wait_cycles(6);
`ifndef DEBUG_DISPLAY_PAGER_AUTOSCROLL_EN
    @(negedge clock);
    check("page0_hex", 64'(hex_out), 64'({7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}));
    wait_cycles(1);
    pulse_step();
    wait_cycles(6);
    @(negedge clock);
    check("page1_hex", 64'(hex_out), 64'({7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24}));
    check("page1_led", 64'(led_out), 64'(3'b100));
    wait_cycles(1);
    pulse_step();
    wait_cycles(6);
    @(negedge clock);
    check("wrap_led", 64'(led_out), 64'(3'b000));
    wait_cycles(1);

    pulse_freeze();
    wait_cycles(6);
    ch_w[1] = 32'hDEADBEEF;
    wait_cycles(4);
    @(negedge clock);
    check("frozen_hex", 64'(hex_out), 64'({7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}));
    check("frozen_led", 64'(led_out), 64'(3'b001));
    wait_cycles(1);
    pulse_freeze();
    wait_cycles(6);
    @(negedge clock);
    check("unfrozen_hex", 64'(hex_out), 64'({7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E}));
    wait_cycles(1);

    sel_in = 3'd7;
    wait_cycles(6);
    @(negedge clock);
    check("bad_sel_hex", 64'(hex_out), 64'({6{7'h40}}));
    check("bad_sel_led", 64'(led_out), 64'(3'b010));
    wait_cycles(1);
    pulse_step();
    wait_cycles(6);
    @(negedge clock);
    check("bad_sel_page1_led", 64'(led_out), 64'(3'b110));
    wait_cycles(1);
    sel_in = 3'd2;
    wait_cycles(6);
    @(negedge clock);
    check("sel_change_led", 64'(led_out), 64'(3'b000));
    wait_cycles(1);

    sel_in = 3'd3; step_in = 1'b1;
    wait_cycles(1);
    step_in = 1'b0;
    wait_cycles(6);
    @(negedge clock);
    check("step_vs_sel_led", 64'(led_out), 64'(3'b000));
    wait_cycles(1);
    step_in = 1'b1; freeze_in = 1'b1;
    wait_cycles(1);
    step_in = 1'b0; freeze_in = 1'b0;
    wait_cycles(6);
    @(negedge clock);
    check("step_and_freeze_led", 64'(led_out), 64'(3'b101));
    wait_cycles(1);
    pulse_freeze();
    wait_cycles(100);
    @(negedge clock);
    check("static_page_led", 64'(led_out), 64'(3'b100));
    wait_cycles(1);
`else
    wait_cycles(100);
`endif

    // randomized traffic, including occasional mid-run resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) step_in = ~step_in;
      if ($urandom_range(0, 15) == 0) freeze_in = ~freeze_in;
      if ($urandom_range(0, 19) == 0) sel_in = 3'($urandom_range(0, 7));
      ch_w[$urandom_range(0, N_CH - 1)] = $urandom;
      ch_w[sel_in < 3'd6 ? int'(sel_in) : 0] = $urandom;
      reset = ($urandom_range(0, 299) == 0);
      wait_cycles(1);
    end
    reset = 1'b0;
    wait_cycles(3);
    @(negedge clock);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
